// File: rtl/queue_pkg.sv
// Shared constants and the reader FSM state type for the 8-entry byte queue.
package queue_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } reader_state_t;

endpackage

// File: rtl/queue_reader.sv
// Consumer-side dequeue controller: pops one byte at a time and presents it downstream.
// Optional burst grouping is enabled by defining QUEUE_READER_BURST_EN.
module queue_reader #(
    parameter int DATA_W    = queue_pkg::DATA_W,
    parameter int LEN_W     = queue_pkg::LEN_W,
    parameter int BURST_LEN = 4
) (
    input  logic              clock10mhz,
    input  logic              reset,
    input  logic [LEN_W-1:0]  q_len_in,
    input  logic [DATA_W-1:0] q_data_in,
    output logic              q_dequeue_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [15:0]       delivered_out,
    output logic [1:0]        dbg_state_out
);
    import queue_pkg::*;

    if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst_len
        $error("queue_reader: BURST_LEN must be in 1..DEPTH");
    end

    reader_state_t     r_state;
    reader_state_t     w_next;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [15:0]       r_delivered;
    logic              w_xfer;
    logic              w_start;
    logic              w_more;
    logic              w_last_at_capture;

    // Downstream handshake: out_valid rises in PRESENT and holds, with out_data and
    // out_last frozen, until a rising edge sees out_valid & out_ready; that edge is the
    // transfer. out_ready may be held low indefinitely and never affects the queue.
    assign w_xfer = (r_state == PRESENT) && out_ready;

`ifdef QUEUE_READER_BURST_EN
    logic [3:0] r_remaining;

    always_ff @(posedge clock10mhz) begin
        if (reset) begin
            r_remaining <= 4'd0;
        end else if (r_state == IDLE && w_next == POP) begin
            r_remaining <= 4'(BURST_LEN);
        end else if (w_xfer) begin
            r_remaining <= r_remaining - 4'd1;
        end
    end

    // The whole burst is already counted in the queue, so no re-check of q_len_in mid-burst.
    assign w_start           = q_len_in >= LEN_W'(BURST_LEN);
    assign w_more            = r_remaining > 4'd1;
    assign w_last_at_capture = r_remaining == 4'd1;
`else
    assign w_start           = q_len_in != '0;
    assign w_more            = q_len_in != '0;
    assign w_last_at_capture = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = POP;
            POP:     w_next = CAPTURE;
            CAPTURE: w_next = PRESENT;
            PRESENT: if (w_xfer) w_next = w_more ? POP : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock10mhz) begin
        if (reset) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_delivered <= 16'd0;
        end else begin
            r_state <= w_next;
            // The queue drives the popped byte during the cycle after the dequeue pulse.
            if (r_state == CAPTURE) begin
                r_data <= q_data_in;
                r_last <= w_last_at_capture;
            end
            if (w_xfer) begin
                r_delivered <= r_delivered + 16'd1;
            end
        end
    end

    assign q_dequeue_out = (r_state == POP);
    assign out_valid     = (r_state == PRESENT);
    assign out_data      = r_data;
    assign out_last      = r_last;
    assign delivered_out = r_delivered;
    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_queue_reader.sv
// Scoreboard bench for queue_reader with a behavioural model of the byte queue.
module tb_queue_reader;
  import queue_pkg::*;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [LW-1:0] q_len_in = '0;
  logic [DW-1:0] q_data_in = 8'hEE;
  logic          q_dequeue_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [15:0]   delivered_out;
  logic [1:0]    dbg_state_out;

  int checks = 0;
  int failures = 0;

  logic [7:0]  q_model[$];
  logic [8:0]  exp_q[$];
  logic [15:0] exp_delivered = 16'd0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  queue_reader #(.DATA_W(DW), .LEN_W(LW), .BURST_LEN(BL)) dut (
    .clock10mhz   (clk),
    .reset        (reset),
    .q_len_in     (q_len_in),
    .q_data_in    (q_data_in),
    .q_dequeue_out(q_dequeue_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .delivered_out(delivered_out),
    .dbg_state_out(dbg_state_out)
  );

  // clock / reset: posedge at 5, 15, ...; stimulus at posedge+2; sampling at negedge
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // queue model: byte appears on q_data_in the cycle after the pulse
  always @(posedge clk) begin
    if (q_dequeue_out && q_model.size() > 0) q_data_in <= q_model.pop_front();
    else q_data_in <= 8'hEE;
    q_len_in <= LW'(q_model.size());
  end

  // driver tasks
  task automatic push(input logic [7:0] d, input logic last);
    q_model.push_back(d);
    exp_q.push_back({last, d});
  endtask

  task automatic wait_valid(input int bound, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({name, "_timeout"}, 32'(out_valid), 32'(1));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] e;
    check("delivered", 32'(delivered_out), 32'(exp_delivered));
    if (q_dequeue_out) check("deq_nonempty", 32'(q_len_in != '0), 32'(1));
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'(1));
      check("stall_data", 32'(out_data), 32'(prev_data));
    end
    if (reset) begin
      exp_q.delete();
      exp_delivered = 16'd0;
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_last", 32'(out_last), 32'(e[8]));
        end
        exp_delivered = exp_delivered + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // empty queue: nothing happens, outputs stay at reset values
    repeat (20) begin
      @(negedge clk);
      check("idle_deq", 32'(q_dequeue_out), 32'(0));
      check("idle_valid", 32'(out_valid), 32'(0));
      check("idle_data", 32'(out_data), 32'(0));
      check("idle_last", 32'(out_last), 32'(0));
      check("idle_state", 32'(dbg_state_out), 32'(IDLE));
    end

`ifndef QUEUE_READER_BURST_EN
    // single byte, minimum latency
    @(posedge clk); #2 push(8'hA5, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("a5_deq", 32'(q_dequeue_out), 32'(c == 1));
      check("a5_valid", 32'(out_valid), 32'(c == 3));
      if (c == 3) begin
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_last", 32'(out_last), 32'(1));
      end
    end
    check("a5_count", 32'(delivered_out), 32'(1));

    // three bytes back-to-back: pulses 3 cycles apart
    @(posedge clk); #2;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("b2b_deq", 32'(q_dequeue_out), 32'(c == 1 || c == 4 || c == 7));
      check("b2b_valid", 32'(out_valid), 32'(c == 3 || c == 6 || c == 9));
    end
    check("b2b_state", 32'(dbg_state_out), 32'(IDLE));
    check("b2b_count", 32'(delivered_out), 32'(4));

    // downstream stall in PRESENT
    @(posedge clk); #2;
    out_ready = 1'b0;
    push(8'h5C, 1'b1);
    wait_valid(20, "stall");
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_data", 32'(out_data), 32'h5C);
      check("hold_deq", 32'(q_dequeue_out), 32'(0));
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(negedge clk);
    check("rel_valid_pre", 32'(out_valid), 32'(1));
    @(negedge clk);
    check("rel_valid_post", 32'(out_valid), 32'(0));
    check("rel_count", 32'(delivered_out), 32'(5));

    // reset during PRESENT discards the undelivered byte
    @(posedge clk); #2;
    out_ready = 1'b0;
    push(8'h77, 1'b1);
    wait_valid(20, "rst");
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_state", 32'(dbg_state_out), 32'(IDLE));
    check("rst_count", 32'(delivered_out), 32'(0));
    @(posedge clk); #2;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("rst_no_replay", 32'(out_valid), 32'(0));
      check("rst_no_deq", 32'(q_dequeue_out), 32'(0));
    end
`else
    // burst: nothing until BURST_LEN bytes are queued
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2 push(8'hB0 + 8'(i), 1'b0);
      repeat (4) begin
        @(negedge clk);
        check("burst_wait_deq", 32'(q_dequeue_out), 32'(0));
      end
    end
    @(posedge clk); #2 push(8'hB3, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check("burst_deq", 32'(q_dequeue_out), 32'(c == 1 || c == 4 || c == 7 || c == 10));
      if (out_valid) check("burst_last", 32'(out_last), 32'(c == 12));
    end
    check("burst_state", 32'(dbg_state_out), 32'(IDLE));
    check("burst_count", 32'(delivered_out), 32'(4));
`endif

    // drain and final state
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    check("queue_empty", 32'(q_model.size()), 32'(0));
    @(negedge clk);
    check("end_state", 32'(dbg_state_out), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
